pin_chain_tester: RTL and testbench



---
 rtl/pin_chain_tester.sv | 164 ++++++++++++++++
 tb/tb_pin_chain_tester.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pin_chain_tester.sv
// Initiator for the jig pin loopback chain: drives zeros/ones/walking-one/walking-zero patterns
// and checks the synchronized return. Optional Hi-Z float step via PIN_CHAIN_HIZ_CHECK_EN.
module pin_chain_tester #(
  parameter int unsigned NPINS         = 17,
  parameter int unsigned SETTLE_CYCLES = 8
`ifdef PIN_CHAIN_HIZ_CHECK_EN
  ,
  parameter logic        HIZ_EXPECT    = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [NPINS-1:0] drive_o,
  output logic             oe_o,
  input  logic [NPINS-1:0] sense_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NPINS-1:0] fail_mask,
  output logic [7:0]       fail_count
);

`ifdef PIN_CHAIN_HIZ_CHECK_EN
  localparam int unsigned NSTEPS = 3 + 2 * NPINS;
`else
  localparam int unsigned NSTEPS = 2 + 2 * NPINS;
`endif
  localparam int unsigned SW = $clog2(NSTEPS);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] LastStep   = SW'(NSTEPS - 1);
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    step_q, step_d;
  logic [NPINS-1:0] drive_q, drive_d;
  logic             oe_q, oe_d;
  logic [NPINS-1:0] mask_q, mask_d;
  logic [7:0]       count_q, count_d;
  logic             pass_q, pass_d;
  logic [NPINS-1:0] sync1_q, sync2_q;
  logic [NPINS-1:0] expected, mismatch;

  // Pattern driven for a given step; the float step (if any) drives zeros.
  function automatic logic [NPINS-1:0] pattern(input int unsigned s);
    logic [NPINS-1:0] one;
    logic [NPINS-1:0] p;
    one    = '0;
    one[0] = 1'b1;
    p      = '0;
    if (s == 1) begin
      p = '1;
    end else if (s >= 2 && s < NPINS + 2) begin
      p = one << (s - 2);
    end else if (s >= NPINS + 2 && s < 2 * NPINS + 2) begin
      p = ~(one << (s - NPINS - 2));
    end
    return p;
  endfunction

`ifdef PIN_CHAIN_HIZ_CHECK_EN
  assign expected = (step_q == LastStep) ? {NPINS{HIZ_EXPECT}} : drive_q;
`else
  assign expected = drive_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    drive_d  = drive_q;
    oe_d     = oe_q;
    mask_d   = mask_q;
    count_d  = count_q;
    pass_d   = pass_q;
    mismatch = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = '0;
          count_d = '0;
          pass_d  = 1'b0;
          oe_d    = 1'b1;
          step_d  = '0;
          drive_d = pattern(0);
          cnt_d   = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        mismatch = sync2_q ^ expected;
        mask_d   = mask_q | mismatch;
        if (|mismatch && count_q != 8'hff) begin
          count_d = count_q + 8'd1;
        end
        if (step_q == LastStep) begin
          pass_d  = (mask_d == '0);
          oe_d    = 1'b0;
          drive_d = '0;
          state_d = StFinish;
        end else begin
          step_d  = step_q + 1'b1;
          drive_d = pattern(32'(step_d));
          cnt_d   = '0;
`ifdef PIN_CHAIN_HIZ_CHECK_EN
          oe_d    = (step_d != LastStep);
`else
          oe_d    = 1'b1;
`endif
          state_d = StDrive;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= '0;
      drive_q <= '0;
      oe_q    <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      drive_q <= drive_d;
      oe_q    <= oe_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      sync1_q <= sense_i;
      sync2_q <= sync1_q;
    end
  end

  assign drive_o    = drive_q;
  assign oe_o       = oe_q;
  assign busy       = (state_q == StDrive) || (state_q == StSample);
  assign done       = (state_q == StFinish);
  assign pass       = pass_q;
  assign fail_mask  = mask_q;
  assign fail_count = count_q;

endmodule

// File: tb/tb_pin_chain_tester.sv
// Scoreboard bench for pin_chain_tester: a behavioural loopback with injectable faults feeds
// sense_i; expected run results are queued at start and checked when done pulses.
module tb_pin_chain_tester;
  localparam int NP     = 17;
  localparam int SETTLE = 8;
`ifdef PIN_CHAIN_HIZ_CHECK_EN
  localparam int RUN_CYCLES = 333;  // 37 steps * 9
  localparam int ALL_STEPS  = 37;
`else
  localparam int RUN_CYCLES = 324;  // 36 steps * 9
  localparam int ALL_STEPS  = 36;
`endif

  typedef struct {
    logic          pass;
    logic [NP-1:0] mask;
    logic [7:0]    count;
  } exp_t;

  logic          clk, rst_n, start;
  logic [NP-1:0] drive_o, sense_i, fail_mask;
  logic          oe_o, busy, done, pass;
  logic [7:0]    fail_count;

  int   checks = 0;
  int   errors = 0;
  int   busy_cycles = 0;
  int   mode = 0;
  exp_t sb[$];

  pin_chain_tester #(.NPINS(NP), .SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .drive_o    (drive_o),
    .oe_o       (oe_o),
    .sense_i    (sense_i),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_mask  (fail_mask),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback chain with one cycle of delay and selectable faults.
  always @(posedge clk) begin
    logic [NP-1:0] v;
    logic          b;
    v = drive_o;
    case (mode)
      1: v[5] = 1'b0;
      2: begin b = v[0] | v[1]; v[0] = b; v[1] = b; end
      3: v = ~drive_o;
      4: if (!oe_o) v[3] = 1'b1;
      default: ;
    endcase
    sense_i <= v;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cycles = 0;
    end else begin
      if (busy) busy_cycles++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = sb.pop_front();
          check("pass", 32'(pass), 32'(e.pass));
          check("fail_mask", 32'(fail_mask), 32'(e.mask));
          check("fail_count", 32'(fail_count), 32'(e.count));
          check("busy_cycles", 32'(busy_cycles), 32'(RUN_CYCLES));
          check("oe_at_done", 32'(oe_o), 32'd0);
          check("drive_at_done", 32'(drive_o), 32'd0);
        end
        busy_cycles = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic p, input logic [NP-1:0] m, input logic [7:0] c);
    exp_t e;
    e.pass = p; e.mask = m; e.count = c;
    sb.push_back(e);
    pulse_start();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 2000 cycles", name);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oe"}, 32'(oe_o), 32'd0);
    check({tag, "_drive"}, 32'(drive_o), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_mask"}, 32'(fail_mask), 32'd0);
    check({tag, "_count"}, 32'(fail_count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    mode = 0; run(1'b1, 17'h00000, 8'd0);  wait_done("ideal");
    mode = 1; run(1'b0, 17'h00020, 8'd18); wait_done("stuck5");
    mode = 2; run(1'b0, 17'h00003, 8'd4);  wait_done("bridge01");
    mode = 3; run(1'b0, 17'h1ffff, 8'(ALL_STEPS)); wait_done("inverted");

    // Status holds in idle until the next accepted start.
    repeat (5) @(posedge clk);
    #1 check("hold_mask", 32'(fail_mask), 32'h1ffff);
    check("hold_busy", 32'(busy), 32'd0);

    // A second start mid-run must be ignored.
    mode = 1;
    run(1'b0, 17'h00020, 8'd18);
    repeat (50) @(posedge clk);
    pulse_start();
    wait_done("restart_ignored");
    #1 check("no_rerun_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run: outputs drop immediately, no done.
    mode = 0;
    pulse_start();
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("midrun_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run(1'b1, 17'h00000, 8'd0);
    wait_done("after_reset");

`ifdef PIN_CHAIN_HIZ_CHECK_EN
    mode = 4; run(1'b0, 17'h00008, 8'd1); wait_done("hiz_bit3");
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
